// File: rtl/rsa_pkg.sv
// Shared definitions for the framed RSA command/response controller:
// opcodes, reply codes, FSM state encoding and payload sizing.
package rsa_pkg;

  localparam logic [7:0] OP_LOAD_N = 8'h01;
  localparam logic [7:0] OP_LOAD_E = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  localparam logic [7:0] RSP_BAD_OP   = 8'hE0;
  localparam logic [7:0] RSP_BAD_CSUM = 8'hEE;
  localparam logic [7:0] RSP_NO_KEY   = 8'hE1;
  localparam logic [7:0] RSP_ACK      = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_PAY,
    ST_RX_CSUM,
    ST_SCAN_E,
    ST_EXEC_WR,
    ST_EXEC_WAIT,
    ST_TX_SEND,
    ST_TX_WAIT_HI,
    ST_TX_WAIT_LO
  } state_t;

  // Number of payload bytes carried by a frame for a given operand width.
  function automatic int unsigned bytes_of(input int unsigned bitlen);
    return bitlen / 8;
  endfunction

endpackage

// File: rtl/msb_scan.sv
// Finds the index of the most significant set bit of a value by counting
// down from the top bit, one bit per cycle, starting on a go pulse.
module msb_scan #(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITLEN-1:0]     value,
  input  logic                  go,
  output logic [LOG_BITLEN-1:0] idx,
  output logic                  done,
  output logic                  zero
);

  logic                  busy_q, busy_d;
  logic [LOG_BITLEN-1:0] cnt_q, cnt_d;
  logic                  hit;

  // Scan is complete on the first set bit or once bit 0 has been examined.
  always_comb begin
    hit   = value[cnt_q];
    done  = busy_q && (hit || (cnt_q == '0));
    zero  = done && !hit;
    idx   = hit ? cnt_q : '0;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (go) begin
      busy_d = 1'b1;
      cnt_d  = LOG_BITLEN'(BITLEN - 1);
    end else if (done) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q - LOG_BITLEN'(1);
    end
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rsa_frame_ctrl.sv
// Packet-level controller between the UART and the Montgomery exponentiator.
// Parses opcode/payload/checksum frames, keeps the key registers, launches a
// run and streams the result back MSB first.
module rsa_frame_ctrl #(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8,
  parameter int ABITS      = 8,
  parameter int TIMEOUT    = 120000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  is_transmitting,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  output logic [BITLEN-1:0]     n,
  output logic [BITLEN-1:0]     e,
  output logic [LOG_BITLEN-1:0] e_idx,
  output logic [ABITS-1:0]      wr_addr,
  output logic [BITLEN-1:0]     wr_data,
  output logic                  wr_en,
  output logic                  start,
  input  logic                  stop,
  input  logic [BITLEN-1:0]     ans
);

  import rsa_pkg::*;

  localparam int unsigned BYTES = bytes_of(BITLEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [BITLEN-1:0]     sh_q, sh_d;
  logic [7:0]            csum_q, csum_d;
  logic [LOG_BITLEN-1:0] cnt_q, cnt_d;
  logic [TW-1:0]         to_q, to_d;
  logic [BITLEN-1:0]     n_q, n_d;
  logic [BITLEN-1:0]     e_q, e_d;
  logic                  n_ok_q, n_ok_d;
  logic                  e_ok_q, e_ok_d;
  logic [LOG_BITLEN-1:0] e_idx_q, e_idx_d;
  logic [BITLEN-1:0]     wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  start_q, start_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [BITLEN-1:0]     res_q, res_d;
  logic [LOG_BITLEN-1:0] tx_left_q, tx_left_d;

  logic                  reply_req;
  logic [7:0]            reply_code;
  logic                  scan_go;
  logic [LOG_BITLEN-1:0] scan_idx;
  logic                  scan_done;
  logic                  scan_zero;

  msb_scan #(
    .BITLEN    (BITLEN),
    .LOG_BITLEN(LOG_BITLEN)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .value(e_q),
    .go   (scan_go),
    .idx  (scan_idx),
    .done (scan_done),
    .zero (scan_zero)
  );

  // Frame parser, run sequencer and transmit handshake; single-byte replies
  // go straight out when the UART is idle so the ACK leaves one cycle early.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sh_d       = sh_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    to_d       = '0;
    n_d        = n_q;
    e_d        = e_q;
    n_ok_d     = n_ok_q;
    e_ok_d     = e_ok_q;
    e_idx_d    = e_idx_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    start_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    res_d      = res_q;
    tx_left_d  = tx_left_q;
    reply_req  = 1'b0;
    reply_code = 8'h00;
    scan_go    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          op_d   = rx_byte;
          csum_d = 8'h00;
          cnt_d  = '0;
          case (rx_byte)
            OP_LOAD_N: begin
              n_ok_d  = 1'b0;
              state_d = ST_RX_PAY;
            end
            OP_LOAD_E: begin
              e_ok_d  = 1'b0;
              state_d = ST_RX_PAY;
            end
            OP_RUN:    state_d = ST_RX_PAY;
            OP_STATUS: begin
              reply_req  = 1'b1;
              reply_code = {6'b0, e_ok_q, n_ok_q};
            end
            default: begin
              reply_req  = 1'b1;
              reply_code = RSP_BAD_OP;
            end
          endcase
        end
      end

      ST_RX_PAY: begin
        if (rx_valid) begin
          sh_d   = {sh_q[BITLEN-9:0], rx_byte};
          csum_d = csum_q ^ rx_byte;
          if (cnt_q == LOG_BITLEN'(BYTES - 1)) begin
            state_d = ST_RX_CSUM;
          end else begin
            cnt_d = cnt_q + LOG_BITLEN'(1);
          end
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      ST_RX_CSUM: begin
        if (rx_valid) begin
          if (rx_byte != csum_q) begin
            reply_req  = 1'b1;
            reply_code = RSP_BAD_CSUM;
          end else begin
            case (op_q)
              OP_LOAD_N: begin
                n_d        = sh_q;
                n_ok_d     = 1'b1;
                reply_req  = 1'b1;
                reply_code = RSP_ACK;
              end
              OP_LOAD_E: begin
                e_d     = sh_q;
                scan_go = 1'b1;
                state_d = ST_SCAN_E;
              end
              OP_RUN: begin
                if (n_ok_q && e_ok_q) begin
                  wr_data_d = sh_q;
                  wr_en_d   = 1'b1;
                  state_d   = ST_EXEC_WR;
                end else begin
                  reply_req  = 1'b1;
                  reply_code = RSP_NO_KEY;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      ST_SCAN_E: begin
        if (scan_done) begin
          e_idx_d    = scan_idx;
          e_ok_d     = !scan_zero;
          reply_req  = 1'b1;
          reply_code = RSP_ACK;
        end
      end

      ST_EXEC_WR: begin
        start_d = 1'b1;
        state_d = ST_EXEC_WAIT;
      end

      ST_EXEC_WAIT: begin
        if (stop) begin
          res_d     = ans;
          tx_left_d = LOG_BITLEN'(BYTES);
          state_d   = ST_TX_SEND;
        end
      end

      ST_TX_SEND: begin
        if (!is_transmitting) begin
          tx_byte_d  = res_q[BITLEN-1 -: 8];
          tx_valid_d = 1'b1;
          res_d      = res_q << 8;
          tx_left_d  = tx_left_q - LOG_BITLEN'(1);
          state_d    = ST_TX_WAIT_HI;
        end
      end

      ST_TX_WAIT_HI: begin
        if (is_transmitting) state_d = ST_TX_WAIT_LO;
      end

      ST_TX_WAIT_LO: begin
        if (!is_transmitting) begin
          state_d = (tx_left_q != '0) ? ST_TX_SEND : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (reply_req) begin
      if (!is_transmitting) begin
        tx_byte_d  = reply_code;
        tx_valid_d = 1'b1;
        tx_left_d  = '0;
        state_d    = ST_TX_WAIT_HI;
      end else begin
        res_d     = {reply_code, {(BITLEN-8){1'b0}}};
        tx_left_d = LOG_BITLEN'(1);
        state_d   = ST_TX_SEND;
      end
    end
  end

  // State, key and datapath registers; reset also drops the keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 8'h00;
      sh_q       <= '0;
      csum_q     <= 8'h00;
      cnt_q      <= '0;
      to_q       <= '0;
      n_q        <= '0;
      e_q        <= '0;
      n_ok_q     <= 1'b0;
      e_ok_q     <= 1'b0;
      e_idx_q    <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      start_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      res_q      <= '0;
      tx_left_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sh_q       <= sh_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      n_q        <= n_d;
      e_q        <= e_d;
      n_ok_q     <= n_ok_d;
      e_ok_q     <= e_ok_d;
      e_idx_q    <= e_idx_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      start_q    <= start_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      res_q      <= res_d;
      tx_left_q  <= tx_left_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign n        = n_q;
  assign e        = e_q;
  assign e_idx    = e_idx_q;
  assign wr_addr  = '0;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign start    = start_q;

endmodule
